mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; the producer side of the 4-bit ALUOp interface consumed by the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives all datapath strobes and muxes.
- ALUOp carries a direct ALU code; 4'b1111 tells the decoder to use the instruction FuncCode.
- Stalls on a memory ready handshake.

Parameters:
- OP_ADD, 4'b0010, ALUOp code for address/PC arithmetic.
- OP_FUNC, 4'b1111, ALUOp code deferring to FuncCode (R-type).

Ports:
- Clk  input  1  clock; all state changes on rising edge
- Rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  IR[31:26], held stable by the IR after fetch
- Zero  input  1  ALU zero flag (used externally with PCWriteCond)
- MemReady  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, SignExt  output  1 each  datapath controls
- ALUSrcB  output  2  00 regB, 01 const 4, 10 immediate, 11 immediate<<2
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  output  4  to ALU control decoder
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode
- State  output  4  current state, for debug

Behaviour:
- Reset: asynchronous, active-low; State=FETCH(0) immediately.
- While Rst_n=0, all 1-bit strobes are 0, ALUSrcB=01, ALUOp=0010, PCSource=00.
- Outputs are Moore (decoded from State). Exception: in FETCH, PCWrite and IRWrite equal MemReady.
- Unlisted outputs are 0 in every state. ALUOp defaults to 0010.
- State encoding: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11. Codes 12-15 go to FETCH on the next edge.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=ADD. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcB=11, ALUOp=ADD. Next state by Opcode:
  - 000000 -> REXEC
  - 100011 (lw) / 101011 (sw) -> MEMADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000/001001/001010/001011/001100/001101/001110/001111 -> IEXEC
  - anything else -> FETCH, with IllegalOp=1 during this DECODE cycle
- MEMADDR: ALUSrcA=1, ALUSrcB=10, SignExt=1, ALUOp=ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Stays while MemReady=0, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
- MEMWR: MemWrite=1, IorD=1. Stays while MemReady=0, then goes to FETCH.
  - MemWrite stays high through the whole stall.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=1111; then RWB.
- RWB: RegWrite=1, RegDst=1; then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; then IWB. ALUOp and SignExt by Opcode:

  | Opcode | Instr | ALUOp | SignExt |
  |---|---|---|---|
  | 001000 | addi | 0010 | 1 |
  | 001001 | addiu | 1000 | 1 |
  | 001010 | slti | 0111 | 1 |
  | 001011 | sltiu | 1011 | 1 |
  | 001100 | andi | 0000 | 0 |
  | 001101 | ori | 0001 | 0 |
  | 001110 | xori | 1010 | 0 |
  | 001111 | lui | 1110 | 0 |

- IWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0110, PCWriteCond=1, PCSource=01; then FETCH. Zero is not used internally.
- JUMP: PCWrite=1, PCSource=10; then FETCH.
- Cycle counts with MemReady always 1:
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each memory wait cycle adds one cycle.
- Reset asserted mid-instruction aborts it: no further strobes; restarts at FETCH after release.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Reset low for 3 cycles, release -> State=0, MemRead=1. With MemReady=1: IRWrite=PCWrite=1, then State=1 on the next edge.
- lw (100011), MemReady low 2 cycles in MEMRD -> State sequence 0,1,2,3,3,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- R-type (000000) -> State sequence 0,1,6,7,0; ALUOp=1111 in state 6; RegDst=RegWrite=1 in state 7.
- ori (001101) -> State 8 with ALUOp=0001, SignExt=0. addi (001000) -> ALUOp=0010, SignExt=1. Both end with RegWrite in state 9.
- beq (000100) -> State 10 with ALUOp=0110, PCWriteCond=1, PCSource=01. j (000010) -> State 11 with PCWrite=1, PCSource=10.
- Opcode 111111 -> IllegalOp pulses for exactly 1 cycle in DECODE, then FETCH. Separately, sw stalled in MEMWR with Rst_n pulsed low -> MemWrite drops asynchronously and State=0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mips_multicycle_control #(
  parameter logic [3:0] OP_ADD  = 4'b0010,
  parameter logic [3:0] OP_FUNC = 4'b1111
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       SignExt,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_IEXEC   = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  state_t state_q, state_d;
  logic   op_legal;

  // Branch resolution happens in the datapath via PCWriteCond & Zero.
  logic   zero_unused;
  assign zero_unused = Zero;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    op_legal = (Opcode == OPC_RTYPE) || (Opcode == OPC_LW) || (Opcode == OPC_SW) ||
               (Opcode == OPC_BEQ) || (Opcode == OPC_J) || (Opcode[5:3] == 3'b001);
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (Opcode == OPC_RTYPE)                        state_d = S_REXEC;
        else if (Opcode == OPC_LW || Opcode == OPC_SW)  state_d = S_MEMADDR;
        else if (Opcode == OPC_BEQ)                     state_d = S_BRANCH;
        else if (Opcode == OPC_J)                       state_d = S_JUMP;
        else if (Opcode[5:3] == 3'b001)                 state_d = S_IEXEC;
        else                                            state_d = S_FETCH;
      end
      S_MEMADDR: state_d = (Opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = MemReady ? S_FETCH : S_MEMWR;
      S_REXEC:   state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_IEXEC:   state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    SignExt     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = OP_ADD;
    IllegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = !op_legal;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        SignExt = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = OP_FUNC;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Logical immediates (andi/ori/xori/lui) are zero-extended.
        SignExt = !Opcode[2];
        case (Opcode[2:0])
          3'b000:  ALUOp = 4'b0010;
          3'b001:  ALUOp = 4'b1000;
          3'b010:  ALUOp = 4'b0111;
          3'b011:  ALUOp = 4'b1011;
          3'b100:  ALUOp = 4'b0000;
          3'b101:  ALUOp = 4'b0001;
          3'b110:  ALUOp = 4'b1010;
          default: ALUOp = 4'b1110;
        endcase
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 4'b0110;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    if (!Rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      SignExt     = 1'b0;
      ALUSrcB     = 2'b01;
      PCSource    = 2'b00;
      ALUOp       = OP_ADD;
      IllegalOp   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized check of the multicycle control FSM
// Each instruction is expanded into its expected per-cycle control word and compared.
module tb_mips_multicycle_control;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, SignExt, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;

  mips_multicycle_control dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .SignExt(SignExt), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, sext;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aluop;
    logic       ill;
    logic [3:0] st;
  } ctl_t;

  int n_checks = 0;
  int n_pass   = 0;

  ctl_t exp_q[$];
  logic rdy_q[$];
  logic [5:0] cur_op;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic ctl_t dut_vec();
    ctl_t c;
    c = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
          RegWrite, ALUSrcA, SignExt, ALUSrcB, PCSource, ALUOp, IllegalOp, State};
    return c;
  endfunction

  function automatic ctl_t base(input int st);
    ctl_t c;
    c = '0;
    c.aluop = 4'b0010;
    c.st = st[3:0];
    return c;
  endfunction

  function automatic ctl_t reset_vec();
    ctl_t c;
    c = '0;
    c.srcb  = 2'b01;
    c.aluop = 4'b0010;
    return c;
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input ctl_t c);
    rdy_q.push_back(rdy);
    exp_q.push_back(c);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic build(input logic [5:0] op, input int fstall, input int mstall);
    ctl_t c;
    logic [3:0] itab [8];
    itab = '{4'b0010, 4'b1000, 4'b0111, 4'b1011, 4'b0000, 4'b0001, 4'b1010, 4'b1110};
    cur_op = op;
    c = base(0); c.mrd = 1; c.srcb = 2'b01;
    for (int i = 0; i < fstall; i++) push(1'b0, c);
    c.pcw = 1; c.irw = 1;
    push(1'b1, c);
    c = base(1); c.srcb = 2'b11;
    if (!(op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h02 ||
          (op >= 6'h08 && op <= 6'h0f))) c.ill = 1;
    push(rnd_bit(), c);
    if (op == 6'h23 || op == 6'h2b) begin
      c = base(2); c.srca = 1; c.srcb = 2'b10; c.sext = 1;
      push(rnd_bit(), c);
      c = (op == 6'h23) ? base(3) : base(5);
      c.iord = 1;
      if (op == 6'h23) c.mrd = 1; else c.mwr = 1;
      for (int i = 0; i < mstall; i++) push(1'b0, c);
      push(1'b1, c);
      if (op == 6'h23) begin
        c = base(4); c.rw = 1; c.m2r = 1;
        push(rnd_bit(), c);
      end
    end else if (op == 6'h00) begin
      c = base(6); c.srca = 1; c.aluop = 4'b1111;
      push(rnd_bit(), c);
      c = base(7); c.rw = 1; c.rdst = 1;
      push(rnd_bit(), c);
    end else if (op >= 6'h08 && op <= 6'h0f) begin
      c = base(8); c.srca = 1; c.srcb = 2'b10;
      c.aluop = itab[op - 6'h08];
      c.sext = (op <= 6'h0b);
      push(rnd_bit(), c);
      c = base(9); c.rw = 1;
      push(rnd_bit(), c);
    end else if (op == 6'h04) begin
      c = base(10); c.srca = 1; c.aluop = 4'b0110; c.pcwc = 1; c.pcsrc = 2'b01;
      push(rnd_bit(), c);
    end else if (op == 6'h02) begin
      c = base(11); c.pcw = 1; c.pcsrc = 2'b10;
      push(rnd_bit(), c);
    end
  endtask

  // Called at a falling edge; leaves off at the next falling edge.
  task automatic run(input string name, input int ncyc);
    int k;
    k = 0;
    while (exp_q.size() > 0 && (ncyc < 0 || k < ncyc)) begin
      Opcode   = cur_op;
      MemReady = rdy_q.pop_front();
      Zero     = rnd_bit();
      #1;
      check_eq($sformatf("%s_op%02h_c%0d", name, cur_op, k), 32'(dut_vec()), 32'(exp_q.pop_front()));
      k++;
      @(negedge Clk);
    end
  endtask

  logic [5:0] legal_ops [15];
  logic [5:0] directed [9];

  initial begin
    legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h09, 6'h0a,
                  6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
    directed  = '{6'h00, 6'h23, 6'h00, 6'h0d, 6'h08, 6'h04, 6'h02, 6'h3f, 6'h2b};
    Rst_n = 1'b0; MemReady = 1'b1; Opcode = 6'h23; Zero = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("reset_c%0d", i), 32'(dut_vec()), 32'(reset_vec()));
      @(negedge Clk);
    end
    Rst_n = 1'b1;

    // lw with two MEMRD wait cycles comes second in the directed list.
    for (int i = 0; i < 9; i++) begin
      build(directed[i], 0, (i == 1) ? 2 : 0);
      run($sformatf("dir%0d", i), -1);
    end

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      if (rnd_bit()) op = legal_ops[$urandom_range(0, 14)];
      else           op = 6'($urandom_range(0, 63));
      build(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run($sformatf("rnd%0d", i), -1);
    end

    // sw stalled in MEMWR, then reset pulsed mid-stall.
    build(6'h2b, 0, 3);
    run("sw_abort", 5);
    exp_q.delete();
    rdy_q.delete();
    #1;
    Rst_n = 1'b0;
    #1;
    check_eq("abort_rst", 32'(dut_vec()), 32'(reset_vec()));
    check_eq("abort_memwrite", 32'(MemWrite), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    build(6'h0d, 1, 0);
    run("after_abort", -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
